// File: rtl/io_timer_irq_sched.sv
// io_timer_irq_sched: round-robin IRQ scheduler for a bank of timer channels.
// Latches rising edges of each timer IRQ as pending, grants one eligible
// channel at a time (AIrq/AVec) until AAck, then enforces a hold-off gap.
// Optional feature: define IO_TIMER_SCHED_TIMEOUT_EN to requeue a grant that
// is not acknowledged within CTimeout enabled cycles (pulses ATimeout).
module io_timer_irq_sched #(
    parameter int CChCnt   = 4,
    parameter int CVecW    = 2,
    parameter int CHoldOff = 3,
    parameter int CTimeout = 255
) (
    input  logic              AClkH,
    input  logic              AResetH,
    input  logic              AClkHEn,
    input  logic [CChCnt-1:0] AReqI,
    input  logic [CChCnt-1:0] AMask,
    input  logic              AAck,
    input  logic [CChCnt-1:0] AOvfClr,
    output logic              AIrq,
    output logic [CVecW-1:0]  AVec,
    output logic [CChCnt-1:0] APend,
    output logic [CChCnt-1:0] AOvf,
    output logic              ATimeout
);

    localparam int HW = (CHoldOff > 1) ? $clog2(CHoldOff) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

    state_t              state, nxt;
    logic [CChCnt-1:0]   req_prev;
    logic [CChCnt-1:0]   rise;
    logic [CChCnt-1:0]   eligible;
    logic [CVecW-1:0]    last;
    logic [CVecW-1:0]    winner;
    logic                found;
    logic [HW-1:0]       hold_cnt;
    logic                hold_done;
    logic                to_hit;
    logic                grant_go;
    logic                to_fire;
    logic [CChCnt-1:0]   clr_mask;
    logic [CChCnt-1:0]   requeue;

    assign rise     = AReqI & ~req_prev;
    assign eligible = APend & AMask;
    assign hold_done = (hold_cnt == HW'(CHoldOff - 1));

`ifdef IO_TIMER_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(CTimeout + 1);
    logic [TW-1:0] to_cnt;

    // Grant age counter; restarts from 0 on every entry to GRANT
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH)
            to_cnt <= '0;
        else if (AClkHEn)
            to_cnt <= (state == S_GRANT) ? to_cnt + 1'b1 : '0;
    end

    // An ack on the same edge beats the timeout
    assign to_hit = (state == S_GRANT) && !AAck && (to_cnt == TW'(CTimeout - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (CTimeout > 0);
    assign to_hit = 1'b0;
`endif

    // Round-robin search starting just after the last granted channel
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= CChCnt; k++) begin
            idx = (int'(last) + k) % CChCnt;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = CVecW'(idx);
            end
        end
    end

    // FSM state register
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH)
            state <= S_IDLE;
        else if (AClkHEn)
            state <= nxt;
    end

    // FSM next-state logic; hold-off of 0 skips HOLD entirely
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (found) nxt = S_GRANT;
            S_GRANT: if (AAck || to_hit) nxt = (CHoldOff == 0) ? S_IDLE : S_HOLD;
            S_HOLD:  if (hold_done) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // FSM strobes: grant entry clears the winner, timeout requeues the grantee
    always_comb begin
        grant_go = (state == S_IDLE) && found;
        to_fire  = to_hit;
        clr_mask = '0;
        requeue  = '0;
        for (int i = 0; i < CChCnt; i++) begin
            clr_mask[i] = grant_go && (winner == CVecW'(i));
            requeue[i]  = to_fire && (AVec == CVecW'(i));
        end
    end

    // Datapath registers; everything frozen while AClkHEn is low
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            req_prev <= '0;
            APend    <= '0;
            AOvf     <= '0;
            AIrq     <= 1'b0;
            AVec     <= '0;
            last     <= CVecW'(CChCnt - 1);
            hold_cnt <= '0;
            ATimeout <= 1'b0;
        end else if (AClkHEn) begin
            req_prev <= AReqI;
            // rise is applied last so a set beats the grant clear
            APend    <= (APend & ~clr_mask) | rise | requeue;
            AOvf     <= (AOvf & ~AOvfClr) | (rise & APend);
            AIrq     <= (nxt == S_GRANT);
            ATimeout <= to_fire;
            hold_cnt <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
            if (grant_go) begin
                AVec <= winner;
                last <= winner;
            end else if (nxt != S_GRANT) begin
                AVec <= '0;
            end
        end
    end

endmodule
